// File: rtl/instr_issuer.sv
// Feeds a small program buffer to the CPU one word at a time: one newinstr strobe
// per word, SETTLE quiet cycles after each, stopping at prog_len words or a halt word.
module instr_issuer #(
  parameter int DEPTH = 32,
  parameter int SETTLE = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(SETTLE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          abort,
  output logic [31:0]   instrword,
  output logic          newinstr,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam logic [31:0] HALT_WORD = 32'hFC000000;

  // Handshake: none. start/load_en are single-cycle requests honoured only in IDLE;
  // newinstr and done are one-cycle strobes with no back-pressure from the CPU.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_buf [DEPTH];
  logic [31:0]   r_instrword;
  logic          r_newinstr;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [CW-1:0] r_cnt;

  state_t        w_next_state;
  logic [31:0]   w_next_instrword;
  logic          w_next_newinstr;
  logic [AW-1:0] w_next_pc;
  logic [AW:0]   w_next_len;
  logic [CW-1:0] w_next_cnt;
  logic [AW:0]   w_start_len;
  logic          w_halt;
  logic          w_last;

  assign w_start_len = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign w_halt      = (r_buf[r_pc] == HALT_WORD);
  assign w_last      = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));

  always_comb begin
    w_next_state     = r_state;
    w_next_instrword = r_instrword;
    w_next_newinstr  = 1'b0;
    w_next_pc        = r_pc;
    w_next_len       = r_len;
    w_next_cnt       = r_cnt;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_next_len   = w_start_len;
            w_next_pc    = '0;
            w_next_state = (w_start_len == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_halt) begin
            w_next_state = S_DONE;
          end else begin
            w_next_instrword = r_buf[r_pc];
            w_next_newinstr  = 1'b1;
            w_next_cnt       = CW'(SETTLE);
            w_next_state     = S_WAIT;
          end
        end
        S_WAIT: begin
          // The strobe cycle sits in WAIT but is not one of the SETTLE quiet cycles.
          if (!r_newinstr) begin
            if (r_cnt == CW'(1)) begin
              if (w_last) begin
                w_next_state = S_DONE;
              end else begin
                w_next_pc    = r_pc + AW'(1);
                w_next_state = S_ISSUE;
              end
            end else begin
              w_next_cnt = r_cnt - CW'(1);
            end
          end
        end
        S_DONE: begin
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_instrword <= '0;
      r_newinstr  <= 1'b0;
      r_pc        <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next_state;
      r_instrword <= w_next_instrword;
      r_newinstr  <= w_next_newinstr;
      r_pc        <= w_next_pc;
      r_len       <= w_next_len;
      r_cnt       <= w_next_cnt;
    end
  end

  // Program storage survives reset so a reset does not force a reload.
  always_ff @(posedge clock) begin
    if (load_en && (r_state == S_IDLE)) begin
      r_buf[load_addr] <= load_data;
    end
  end

  assign instrword = r_instrword;
  assign newinstr  = r_newinstr;
  assign pc        = r_pc;
  assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: random programs checked against a word-list/timing model
// derived from the issue rules (pulse k at 1+k*(SETTLE+2) cycles after start).
module tb_instr_issuer;
  localparam int DEPTH = 32;
  localparam int SETTLE = 4;
  localparam int AW = 5;
  localparam int P = SETTLE + 2;
  localparam logic [31:0] HALT = 32'hFC000000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          abort = 1'b0;
  logic [31:0]   instrword;
  logic          newinstr;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  instr_issuer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len), .abort(abort),
    .instrword(instrword), .newinstr(newinstr), .pc(pc), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: buffer image, last issued word, final pc.
  logic [31:0] mem [DEPTH];
  logic [31:0] model_instr = '0;
  int          model_pc = 0;
  logic [31:0] exp_q [$];
  int          exp_t [$];
  int          exp_pc [$];

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // All driver tasks start and end just after a falling edge.
  task automatic load_word(input int addr, input logic [31:0] data);
    load_en = 1'b1; load_addr = AW'(addr); load_data = data;
    @(negedge clock);
    load_en = 1'b0;
    mem[addr] = data;
  endtask

  task automatic run_and_check(input int plen, input bit noise, input string name);
    int len, nissue, done_t, ep, et;
    bit halted, seen_done;
    logic [31:0] ew;
    len = (plen > DEPTH) ? DEPTH : plen;
    halted = 1'b0; nissue = 0;
    for (int i = 0; i < len; i++) begin
      if (mem[i] == HALT) begin halted = 1'b1; break; end
      exp_q.push_back(mem[i]); exp_t.push_back(1 + P * i); exp_pc.push_back(i);
      nissue++;
    end
    done_t = (len == 0) ? 0 : (halted ? P * nissue + 1 : P * nissue);
    model_pc = (len == 0) ? 0 : (halted ? nissue : len - 1);
    if (nissue > 0) model_instr = mem[nissue-1];

    start = 1'b1; prog_len = (AW+1)'(plen);
    @(negedge clock);
    start = 1'b0;
    seen_done = 1'b0;
    for (int t = 0; t <= P * DEPTH + 8; t++) begin
      n_vec++;
      if (busy !== (t < done_t)) begin
        n_err++; $display("FAIL %s busy t=%0d got %b want %b", name, t, busy, (t < done_t));
      end
      if (newinstr === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL %s extra_pulse t=%0d got newinstr 1 want 0", name, t);
        end else begin
          ew = exp_q.pop_front(); et = exp_t.pop_front(); ep = exp_pc.pop_front();
          n_vec += 2;
          if (instrword !== ew) begin
            n_err++; $display("FAIL %s instrword t=%0d got %h want %h", name, t, instrword, ew);
          end
          if (t !== et) begin
            n_err++; $display("FAIL %s pulse_time got %0d want %0d", name, t, et);
          end
          if (pc !== AW'(ep)) begin
            n_err++; $display("FAIL %s pulse_pc got %0d want %0d", name, pc, ep);
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        n_vec++;
        if (t !== done_t) begin
          n_err++; $display("FAIL %s done_time got %0d want %0d", name, t, done_t);
        end
      end
      if (noise && !seen_done) begin
        load_en   = 1'($urandom_range(0, 1));
        load_addr = AW'($urandom_range(0, DEPTH - 1));
        load_data = $urandom;
        start     = 1'($urandom_range(0, 1));
      end else begin
        load_en = 1'b0; start = 1'b0;
      end
      if (seen_done) break;
      @(negedge clock);
    end
    load_en = 1'b0; start = 1'b0;
    n_vec += 2;
    if (!seen_done) begin
      n_err++; $display("FAIL %s done_timeout got no done want done at %0d", name, done_t);
    end
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s missing_pulses got %0d short want 0", name, exp_q.size());
    end
    exp_q.delete(); exp_t.delete(); exp_pc.delete();
    @(negedge clock);
    n_vec += 4;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL %s done_after got %b want 0", name, done); end
    if (pc !== AW'(model_pc)) begin
      n_err++; $display("FAIL %s final_pc got %0d want %0d", name, pc, model_pc);
    end
    if (instrword !== model_instr) begin
      n_err++; $display("FAIL %s final_instr got %h want %h", name, instrword, model_instr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    n_vec += 5;
    if (instrword !== 32'h0) begin n_err++; $display("FAIL reset instrword got %h want 0", instrword); end
    if (newinstr !== 1'b0) begin n_err++; $display("FAIL reset newinstr got %b want 0", newinstr); end
    if (pc !== '0) begin n_err++; $display("FAIL reset pc got %0d want 0", pc); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset done got %b want 0", done); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clock);
    model_instr = '0; model_pc = 0;
  endtask

  task automatic test_basic();
    load_word(0, 32'h00221820);  // add $3,$1,$2
    load_word(1, 32'h8C240000);  // lw  $4,0($1)
    load_word(2, 32'hAC240004);  // sw  $4,4($1)
    run_and_check(3, 1'b0, "basic3");
  endtask

  task automatic test_len0();
    run_and_check(0, 1'b0, "len0");
  endtask

  task automatic test_halt();
    load_word(0, rand_word());
    load_word(1, HALT);
    load_word(2, rand_word());
    load_word(3, rand_word());
    run_and_check(4, 1'b0, "halt");
  endtask

  task automatic test_abort();
    int pulses, extra;
    for (int i = 0; i < 4; i++) load_word(i, rand_word());
    start = 1'b1; prog_len = 6'd4;
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    for (int t = 0; t <= 2 * P + 2; t++) begin
      if (newinstr === 1'b1) pulses++;
      if (t == 2 * P + 2) abort = 1'b1;
      @(negedge clock);
    end
    abort = 1'b0;
    n_vec += 6;
    if (pulses !== 3) begin n_err++; $display("FAIL abort pulses_before got %0d want 3", pulses); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort busy got %b want 0", busy); end
    if (newinstr !== 1'b0) begin n_err++; $display("FAIL abort newinstr got %b want 0", newinstr); end
    if (done !== 1'b0) begin n_err++; $display("FAIL abort done got %b want 0", done); end
    if (pc !== AW'(2)) begin n_err++; $display("FAIL abort pc got %0d want 2", pc); end
    if (instrword !== mem[2]) begin
      n_err++; $display("FAIL abort instrword got %h want %h", instrword, mem[2]);
    end
    extra = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clock);
      if (newinstr !== 1'b0 || done !== 1'b0) extra++;
    end
    n_vec++;
    if (extra !== 0) begin n_err++; $display("FAIL abort quiet got %0d strobes want 0", extra); end
    model_pc = 2; model_instr = mem[2];
    abort = 1'b1; start = 1'b1; prog_len = 6'd3;
    @(negedge clock);
    abort = 1'b0; start = 1'b0;
    @(negedge clock);
    n_vec += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_start busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL abort_start done got %b want 0", done); end
    run_and_check(4, 1'b0, "abort_restart");
  endtask

  task automatic test_back_to_back_noise();
    for (int i = 0; i < 3; i++) load_word(i, rand_word());
    run_and_check(3, 1'b1, "noise_run");
    run_and_check(3, 1'b0, "noise_readback");
  endtask

  task automatic test_reset_mid();
    int extra;
    for (int i = 0; i < 3; i++) load_word(i, rand_word());
    start = 1'b1; prog_len = 6'd3;
    @(negedge clock);
    start = 1'b0;
    for (int t = 0; t <= P + 3; t++) begin
      if (t == P + 3) reset = 1'b1;
      @(negedge clock);
    end
    reset = 1'b0;
    n_vec += 5;
    if (instrword !== 32'h0) begin n_err++; $display("FAIL rstmid instrword got %h want 0", instrword); end
    if (newinstr !== 1'b0) begin n_err++; $display("FAIL rstmid newinstr got %b want 0", newinstr); end
    if (pc !== '0) begin n_err++; $display("FAIL rstmid pc got %0d want 0", pc); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rstmid done got %b want 0", done); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy got %b want 0", busy); end
    extra = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clock);
      if (newinstr !== 1'b0 || done !== 1'b0) extra++;
    end
    n_vec++;
    if (extra !== 0) begin n_err++; $display("FAIL rstmid quiet got %0d strobes want 0", extra); end
    model_instr = '0; model_pc = 0;
    run_and_check(3, 1'b0, "rstmid_retain");
  endtask

  task automatic test_depth_plus1();
    for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
    run_and_check(DEPTH + 1, 1'b0, "depth_plus1");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        load_word($urandom_range(0, DEPTH - 1),
                  ($urandom_range(0, 5) == 0) ? HALT : rand_word());
      end
      run_and_check($urandom_range(0, DEPTH + 1), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_len0();
    test_halt();
    test_abort();
    test_back_to_back_noise();
    test_reset_mid();
    test_depth_plus1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
